// File: rtl/axis_pkg.sv
// rtl/axis_pkg.sv - shared arbiter state encoding and pointer sizing helper
//
// Contents:
//   arb_state_t : ARB_IDLE (no packet locked), ARB_LOCKED (grant held on one port)
//   func_log2   : ceil(log2(value)), used to size the round-robin pointer

package axis_pkg;

   typedef enum logic {
      ARB_IDLE   = 1'b0,
      ARB_LOCKED = 1'b1
   } arb_state_t;

   function automatic int func_log2(input int value);
      int result;
      result = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) begin
            result = i + 1;
         end
      end
      return result;
   endfunction

endpackage

// File: rtl/axis_rr_arbiter.sv
// rtl/axis_rr_arbiter.sv - round-robin arbiter with optional packet lock
//
// Build option: AXIS_FAN_IN_PACKET_LOCK_EN (defined = hold grant for a whole packet)
//
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   req          : per-port request (slave tvalid)
//   beat_accept  : a beat from the granted port is accepted this cycle
//   beat_last    : tlast of the granted port
//   grant        : one-hot grant, all zero when nothing is requested in IDLE

module axis_rr_arbiter
   import axis_pkg::*;
#(
   parameter int NUM_FANIN = 6
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_FANIN-1:0] req,
   input  logic                 beat_accept,
   input  logic                 beat_last,
   output logic [NUM_FANIN-1:0] grant
);

   localparam int                PTR_W     = func_log2(NUM_FANIN);
   localparam logic [PTR_W-1:0]  LAST_IDX  = PTR_W'(NUM_FANIN - 1);
   localparam logic [PTR_W:0]    NUM_PORTS = (PTR_W + 1)'(NUM_FANIN);

`ifdef AXIS_FAN_IN_PACKET_LOCK_EN
   localparam bit LOCK_EN = 1'b1;
`else
   localparam bit LOCK_EN = 1'b0;
`endif

   arb_state_t       state;
   logic [PTR_W-1:0] rr_ptr;
   logic [PTR_W-1:0] lock_idx;
   logic [PTR_W-1:0] win_idx;
   logic [PTR_W-1:0] next_ptr;
   logic [PTR_W:0]   cand;
   logic             found;

   // Search upward from rr_ptr with wrap; one extra bit on cand keeps the
   // modulo correct when NUM_FANIN is not a power of two.
   always_comb begin
      grant   = '0;
      win_idx = lock_idx;
      cand    = '0;
      found   = 1'b0;
      if (state == ARB_LOCKED) begin
         grant[lock_idx] = 1'b1;
      end else begin
         for (int k = 0; k < NUM_FANIN; k++) begin
            cand = {1'b0, rr_ptr} + (PTR_W + 1)'(k);
            if (cand >= NUM_PORTS) begin
               cand = cand - NUM_PORTS;
            end
            if (!found && req[cand[PTR_W-1:0]]) begin
               found                    = 1'b1;
               grant[cand[PTR_W-1:0]]   = 1'b1;
               win_idx                  = cand[PTR_W-1:0];
            end
         end
      end
   end

   assign next_ptr = (win_idx == LAST_IDX) ? '0 : win_idx + 1'b1;

   // Without packet lock the pointer moves on every beat, so packets from
   // different ports may interleave; with lock it only moves on tlast.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ARB_IDLE;
         rr_ptr   <= '0;
         lock_idx <= '0;
      end else if (beat_accept) begin
         if (!LOCK_EN || beat_last) begin
            rr_ptr <= next_ptr;
         end
         if (LOCK_EN) begin
            case (state)
               ARB_IDLE: begin
                  if (!beat_last) begin
                     state    <= ARB_LOCKED;
                     lock_idx <= win_idx;
                  end
               end
               ARB_LOCKED: begin
                  if (beat_last) begin
                     state <= ARB_IDLE;
                  end
               end
               default: state <= ARB_IDLE;
            endcase
         end
      end
   end

endmodule

// File: rtl/axis_fan_in.sv
// rtl/axis_fan_in.sv - many-to-one stream merge with round-robin arbitration and skid output
//
// Build option: AXIS_FAN_IN_PACKET_LOCK_EN (defined = packets are never interleaved)
//
// Ports:
//   s_axis_clk, s_axis_rst : clock, synchronous active-high reset
//   s_axis_tvalid/tready/tlast [NUM_FANIN], s_axis_tdata [NUM_FANIN*DATA_WIDTH]
//                          : packed slave streams, port i at [i*DATA_WIDTH +: DATA_WIDTH]
//   m_axis_tvalid/tready/tdata/tlast : merged master stream
//   m_axis_tdest [NUM_FANIN] : one-hot source port of the current output beat

module axis_fan_in
   import axis_pkg::*;
#(
   parameter int NUM_FANIN  = 6,
   parameter int DATA_WIDTH = 256
) (
   input  logic                            s_axis_clk,
   input  logic                            s_axis_rst,
   input  logic [NUM_FANIN-1:0]            s_axis_tvalid,
   output logic [NUM_FANIN-1:0]            s_axis_tready,
   input  logic [NUM_FANIN*DATA_WIDTH-1:0] s_axis_tdata,
   input  logic [NUM_FANIN-1:0]            s_axis_tlast,
   output logic                            m_axis_tvalid,
   input  logic                            m_axis_tready,
   output logic [DATA_WIDTH-1:0]           m_axis_tdata,
   output logic                            m_axis_tlast,
   output logic [NUM_FANIN-1:0]            m_axis_tdest
);

   logic [NUM_FANIN-1:0]  grant;
   logic                  accept;
   logic [DATA_WIDTH-1:0] sel_data;
   logic                  sel_last;

   logic                  main_valid;
   logic [DATA_WIDTH-1:0] main_data;
   logic                  main_last;
   logic [NUM_FANIN-1:0]  main_dest;

   logic                  skid_valid;
   logic [DATA_WIDTH-1:0] skid_data;
   logic                  skid_last;
   logic [NUM_FANIN-1:0]  skid_dest;

   axis_rr_arbiter #(
      .NUM_FANIN (NUM_FANIN)
   ) u_arb (
      .clk         (s_axis_clk),
      .rst         (s_axis_rst),
      .req         (s_axis_tvalid),
      .beat_accept (accept),
      .beat_last   (sel_last),
      .grant       (grant)
   );

   // Ready looks only at the skid flag, never at m_axis_tready, so the
   // downstream ready has no combinational path back to the slaves.
   assign s_axis_tready = grant & {NUM_FANIN{~skid_valid & ~s_axis_rst}};
   assign accept        = |(s_axis_tvalid & s_axis_tready);

   // AND-OR mux keyed on the one-hot grant.
   always_comb begin
      sel_data = '0;
      for (int i = 0; i < NUM_FANIN; i++) begin
         if (grant[i]) begin
            sel_data = sel_data | s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   assign sel_last = |(grant & s_axis_tlast);

   // Two-entry output buffer: main drives the master port, skid catches the
   // one beat that was already accepted when downstream stalled.
   always_ff @(posedge s_axis_clk) begin
      if (s_axis_rst) begin
         main_valid <= 1'b0;
         main_data  <= '0;
         main_last  <= 1'b0;
         main_dest  <= '0;
         skid_valid <= 1'b0;
         skid_data  <= '0;
         skid_last  <= 1'b0;
         skid_dest  <= '0;
      end else if (main_valid && m_axis_tready) begin
         if (skid_valid) begin
            main_data  <= skid_data;
            main_last  <= skid_last;
            main_dest  <= skid_dest;
            skid_valid <= 1'b0;
         end else if (accept) begin
            main_data  <= sel_data;
            main_last  <= sel_last;
            main_dest  <= grant;
         end else begin
            main_valid <= 1'b0;
         end
      end else if (accept) begin
         if (!main_valid) begin
            main_valid <= 1'b1;
            main_data  <= sel_data;
            main_last  <= sel_last;
            main_dest  <= grant;
         end else begin
            skid_valid <= 1'b1;
            skid_data  <= sel_data;
            skid_last  <= sel_last;
            skid_dest  <= grant;
         end
      end
   end

   assign m_axis_tvalid = main_valid;
   assign m_axis_tdata  = main_data;
   assign m_axis_tlast  = main_last;
   assign m_axis_tdest  = main_dest;

endmodule
